main_memory_responder: RTL

Server end of the `memory_if` request protocol. It sits below the L1-to-L2 request arbiter and stands in for L2/main memory. It accepts one LOAD or STORE at a time from a single requester and performs it on an internal word array. It then answers with a one-cycle `req_fulfilled` pulse after a fixed, parameterised latency.

---
 rtl/main_memory_responder_if.sv | 39 +++
 rtl/main_memory_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder_if.sv
// memory_if request protocol: operation type package plus the request interface.
// The responder uses the server modport, the requester side uses client.
package memory_pkg;
    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;
endpackage

interface memory_if #(
    parameter int XLEN = 32
);
    import memory_pkg::*;

    logic              req_valid;
    logic [XLEN-1:0]   req_address;
    memory_operation_e req_operation;
    logic [XLEN-1:0]   req_store_word;
    logic [XLEN-1:0]   req_loaded_word;
    logic              req_fulfilled;

    modport server (
        input  req_valid,
        input  req_address,
        input  req_operation,
        input  req_store_word,
        output req_loaded_word,
        output req_fulfilled
    );

    modport client (
        output req_valid,
        output req_address,
        output req_operation,
        output req_store_word,
        input  req_loaded_word,
        input  req_fulfilled
    );
endinterface

// File: rtl/main_memory_responder.sv
// main_memory_responder: stands in for L2/main memory at the bottom of the
// memory_if request chain. One LOAD or STORE at a time, answered with a
// single-cycle req_fulfilled pulse LATENCY cycles after acceptance.
//
// Optional feature macro: MAIN_MEM_BOUNDS_CHECK_EN
//   defined   - address bits above the array index are checked at acceptance;
//               out-of-range STOREs are dropped, LOADs return zero, and the
//               addr_error output pulses with req_fulfilled.
//   undefined - upper address bits are ignored (addresses wrap), no addr_error.
module main_memory_responder
    import memory_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int MEM_DEPTH_WORDS = 1024,
    parameter int LATENCY         = 4
) (
    input  logic     clk,
    input  logic     reset_n,
    memory_if.server mem_if
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    ,
    output logic     addr_error
`endif
);

    // Byte offset width inside a word, array index width, latency counter width.
    localparam int OFS  = $clog2(XLEN / 8);
    localparam int IDXW = $clog2(MEM_DEPTH_WORDS);
    localparam int CNTW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e            state_reg;
    logic [CNTW-1:0]   cnt_reg;

    // Request captured at acceptance; nothing on the bus is looked at again
    // until the FSM is back in ST_IDLE.
    logic [IDXW-1:0]   idx_reg;
    memory_operation_e op_reg;
    logic [XLEN-1:0]   store_word_reg;
    logic              oob_reg;

    // Registered outputs.
    logic [XLEN-1:0]   loaded_word_reg;
    logic              fulfilled_reg;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    logic              addr_error_reg;
`endif

    // Word storage; deliberately not reset so contents survive reset_n.
    logic [XLEN-1:0]   mem [MEM_DEPTH_WORDS];

    // Decode of the live request.
    logic [IDXW-1:0]   in_idx;
    logic              in_oob;

    // The access performed on the edge that enters ST_RESPOND.
    logic              commit;
    logic [IDXW-1:0]   commit_idx;
    memory_operation_e commit_op;
    logic [XLEN-1:0]   commit_data;
    logic              commit_oob;
    logic              mem_we;

    // Low byte-offset bits are never looked at; upper bits only with bounds check.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^mem_if.req_address;

    assign in_idx = mem_if.req_address[OFS+IDXW-1:OFS];

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    // Any set bit above the index field means the address is outside the array.
    assign in_oob = ((mem_if.req_address >> (OFS + IDXW)) != '0);
`else
    assign in_oob = 1'b0;
`endif

    // Select the access to commit: with LATENCY==1 the access happens on the
    // accepting edge itself, so it must come straight from the bus; otherwise it
    // comes from the captured request on the last ST_WAIT edge.
    always_comb begin
        commit      = 1'b0;
        commit_idx  = idx_reg;
        commit_op   = op_reg;
        commit_data = store_word_reg;
        commit_oob  = oob_reg;
        if (LATENCY == 1) begin
            commit      = (state_reg == ST_IDLE) && mem_if.req_valid;
            commit_idx  = in_idx;
            commit_op   = mem_if.req_operation;
            commit_data = mem_if.req_store_word;
            commit_oob  = in_oob;
        end else begin
            commit = (state_reg == ST_WAIT) && (cnt_reg == CNTW'(1));
        end
    end

    // Gating with reset_n keeps a STORE from landing while reset is held.
    assign mem_we = commit && (commit_op == STORE) && !commit_oob && reset_n;

    // Array write port; no reset so the contents are retained.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[commit_idx] <= commit_data;
        end
    end

    // Request FSM with latency countdown and registered response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            op_reg          <= LOAD;
            store_word_reg  <= '0;
            oob_reg         <= 1'b0;
            loaded_word_reg <= '0;
            fulfilled_reg   <= 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
            addr_error_reg  <= 1'b0;
`endif
        end else begin
            // Completion flags are single-cycle pulses by default.
            fulfilled_reg <= 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
            addr_error_reg <= 1'b0;
`endif

            // Edge into ST_RESPOND: raise the pulse and capture load data.
            // A STORE leaves loaded_word_reg holding the previous load's value.
            if (commit) begin
                fulfilled_reg <= 1'b1;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
                addr_error_reg <= commit_oob;
`endif
                if (commit_op == LOAD) begin
                    loaded_word_reg <= commit_oob ? '0 : mem[commit_idx];
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (mem_if.req_valid) begin
                        idx_reg        <= in_idx;
                        op_reg         <= mem_if.req_operation;
                        store_word_reg <= mem_if.req_store_word;
                        oob_reg        <= in_oob;
                        cnt_reg        <= CNTW'(LATENCY - 1);
                        state_reg      <= (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - CNTW'(1);
                    if (cnt_reg == CNTW'(1)) begin
                        state_reg <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    // Bus is ignored here; the next request is sampled in ST_IDLE.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_if.req_fulfilled   = fulfilled_reg;
    assign mem_if.req_loaded_word = loaded_word_reg;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    assign addr_error = addr_error_reg;
`endif

endmodule
